// File: rtl/sensor_scheduler.sv
// Shares the DHT11 interface between one-shot host commands and continuous temp/hum reads.
// Optional build macro SCHED_DROP_CONT_ON_ERROR_EN: error responses on continuous reads stop that read.
module sensor_scheduler #(
  parameter int GUARD_CYCLES   = 100_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd,
  output logic       o_cmd_ready,
  output logic       o_if_en,
  output logic [7:0] o_if_request,
  input  logic       i_if_done,
  input  logic [7:0] i_if_data,
  input  logic [5:0] i_if_comandos,
  output logic       o_resp_valid,
  output logic [7:0] o_resp_data,
  output logic [5:0] o_resp_comandos,
  output logic       o_resp_cont,
  output logic       o_busy,
  output logic       o_cont_temp,
  output logic       o_cont_hum
);
  localparam int MAX_GT  = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_ALL = (MAX_GT > RELEASE_CYCLES) ? MAX_GT : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [5:0] CMD_ERR = 6'b000001;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RELEASE, GUARD} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pending_reg;
  logic [7:0]       pending_cmd_reg;
  logic [7:0]       req_reg;
  logic             rr_hum_reg, cur_cont_reg, cur_hum_reg;
  logic [7:0]       cap_data_reg;
  logic [5:0]       cap_cmd_reg;
  logic             resp_valid_reg, resp_cont_reg;
  logic [7:0]       resp_data_reg;
  logic [5:0]       resp_cmd_reg;
  logic [1:0]       cont_flags;

  logic       accept, cmd_known, bad_accept, pick_hum;
  logic       load_pending, load_cont, cap_done, cap_timeout, emit;
  logic [7:0] cmd_mapped;

  assign accept     = i_cmd_valid && !pending_reg;
  assign cmd_known  = (i_cmd >= 8'h31) && (i_cmd <= 8'h37);
  assign bad_accept = accept && !cmd_known;
  // Round-robin only matters when both flags are set; otherwise serve whichever is active.
  assign pick_hum   = cont_flags[1] && (!cont_flags[0] || rr_hum_reg);

  always_comb begin
    cmd_mapped = i_cmd;
    if (i_cmd == 8'h34) cmd_mapped = 8'h32;
    else if (i_cmd == 8'h35) cmd_mapped = 8'h33;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    load_pending = 1'b0;
    load_cont    = 1'b0;
    cap_done     = 1'b0;
    cap_timeout  = 1'b0;
    emit         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          load_pending = 1'b1;
          state_next   = ISSUE;
        end else if (|cont_flags) begin
          load_cont  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_if_done) begin
          cap_done   = 1'b1;
          cnt_next   = '0;
          state_next = RELEASE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          cap_timeout = 1'b1;
          cnt_next    = '0;
          state_next  = RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        // An unknown-command response owns the output this cycle; hold one more cycle.
        if (cnt_reg == RELEASE_LAST) begin
          if (!bad_accept) begin
            emit       = 1'b1;
            cnt_next   = '0;
            state_next = GUARD;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GUARD: begin
        if (cnt_reg == GUARD_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      pending_reg     <= 1'b0;
      pending_cmd_reg <= '0;
      req_reg         <= '0;
      rr_hum_reg      <= 1'b0;
      cur_cont_reg    <= 1'b0;
      cur_hum_reg     <= 1'b0;
      cap_data_reg    <= '0;
      cap_cmd_reg     <= '0;
      resp_valid_reg  <= 1'b0;
      resp_data_reg   <= '0;
      resp_cmd_reg    <= '0;
      resp_cont_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept && cmd_known) begin
        pending_reg     <= 1'b1;
        pending_cmd_reg <= cmd_mapped;
      end else if (load_pending) begin
        pending_reg <= 1'b0;
      end
      if (load_pending) begin
        req_reg      <= pending_cmd_reg;
        cur_cont_reg <= 1'b0;
      end else if (load_cont) begin
        req_reg      <= pick_hum ? 8'h33 : 8'h32;
        cur_cont_reg <= 1'b1;
        cur_hum_reg  <= pick_hum;
      end
      if (cap_done) begin
        cap_data_reg <= i_if_data;
        cap_cmd_reg  <= i_if_comandos;
      end else if (cap_timeout) begin
        cap_data_reg <= 8'h86;
        cap_cmd_reg  <= CMD_ERR;
      end
      resp_valid_reg <= 1'b0;
      if (bad_accept) begin
        resp_valid_reg <= 1'b1;
        resp_data_reg  <= 8'hFF;
        resp_cmd_reg   <= CMD_ERR;
        resp_cont_reg  <= 1'b0;
      end else if (emit) begin
        resp_valid_reg <= 1'b1;
        resp_data_reg  <= cap_data_reg;
        resp_cmd_reg   <= cap_cmd_reg;
        resp_cont_reg  <= cur_cont_reg;
        if (cur_cont_reg) rr_hum_reg <= !cur_hum_reg;
      end
    end
  end

  // Index 0 = temperature (set 0x34 / clear 0x36), index 1 = humidity (set 0x35 / clear 0x37).
  for (genvar gi = 0; gi < 2; gi++) begin : g_cont
    localparam logic [7:0] SET_CODE = 8'(8'h34 + gi);
    localparam logic [7:0] CLR_CODE = 8'(8'h36 + gi);
    logic flag_reg;
    always_ff @(posedge i_Clock) begin
      if (i_Rst) flag_reg <= 1'b0;
      else if (accept && i_cmd == SET_CODE) flag_reg <= 1'b1;
      else if (accept && i_cmd == CLR_CODE) flag_reg <= 1'b0;
`ifdef SCHED_DROP_CONT_ON_ERROR_EN
      else if (emit && cur_cont_reg && cur_hum_reg == 1'(gi) && cap_cmd_reg == CMD_ERR)
        flag_reg <= 1'b0;
`else
      else flag_reg <= flag_reg;
`endif
    end
    assign cont_flags[gi] = flag_reg;
  end

  assign o_cmd_ready     = !pending_reg;
  assign o_if_en         = (state_reg == WAIT_DONE);
  assign o_if_request    = req_reg;
  assign o_resp_valid    = resp_valid_reg;
  assign o_resp_data     = resp_data_reg;
  assign o_resp_comandos = resp_cmd_reg;
  assign o_resp_cont     = resp_cont_reg;
  assign o_busy          = (state_reg != IDLE);
  assign o_cont_temp     = cont_flags[0];
  assign o_cont_hum      = cont_flags[1];
endmodule

// File: tb/tb_sensor_scheduler.sv
// Scoreboard bench for sensor_scheduler: directed commands, a scripted sensor model,
// and a response monitor comparing against queued expectations.
module tb_sensor_scheduler;
  localparam int G = 20;
  localparam int T = 50;
  localparam int R = 2;

  logic       i_Clock = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic [7:0] i_cmd = '0;
  logic       i_if_done = 1'b0;
  logic [7:0] i_if_data = '0;
  logic [5:0] i_if_comandos = '0;
  logic       o_cmd_ready, o_if_en, o_resp_valid, o_resp_cont, o_busy, o_cont_temp, o_cont_hum;
  logic [7:0] o_if_request, o_resp_data;
  logic [5:0] o_resp_comandos;

  sensor_scheduler #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T), .RELEASE_CYCLES(R)) dut (
    .i_Clock(i_Clock), .i_Rst(i_Rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .o_if_en(o_if_en), .o_if_request(o_if_request),
    .i_if_done(i_if_done), .i_if_data(i_if_data), .i_if_comandos(i_if_comandos),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .o_resp_comandos(o_resp_comandos),
    .o_resp_cont(o_resp_cont), .o_busy(o_busy), .o_cont_temp(o_cont_temp), .o_cont_hum(o_cont_hum)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct packed {logic [7:0] data; logic [5:0] cmd; logic cont;} resp_t;
  typedef struct {logic [7:0] data; logic [5:0] cmd; int delay;} sens_t;

  resp_t      exp_resp_q[$];
  logic [7:0] exp_req_q[$];
  sens_t      sens_q[$];
  int         rise_cyc[$];
  int         resp_cyc[$];
  int compared = 0, mismatched = 0, cyc = 0, resp_seen = 0, rise_seen = 0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge i_Clock) begin : monitor
    resp_t got, want;
    if (o_resp_valid === 1'b1) begin
      got = {o_resp_data, o_resp_comandos, o_resp_cont};
      resp_seen++;
      resp_cyc.push_back(cyc);
      $display("resp #%0d cycle %0d: data=%02h comandos=%06b cont=%0b",
               resp_seen, cyc, o_resp_data, o_resp_comandos, o_resp_cont);
      check("resp_expected", 32'(exp_resp_q.size() > 0), 32'd1);
      if (exp_resp_q.size() > 0) begin
        want = exp_resp_q.pop_front();
        check("resp_fields", 32'(got), 32'(want));
      end
    end
  end

  // Sensor interface model: checks each request, then replies if a reply is scripted.
  initial begin : if_model
    sens_t s;
    forever begin
      @(posedge o_if_en);
      #1;
      rise_seen++;
      rise_cyc.push_back(cyc);
      $display("issue #%0d cycle %0d: request=%02h", rise_seen, cyc, o_if_request);
      check("req_expected", 32'(exp_req_q.size() > 0), 32'd1);
      if (exp_req_q.size() > 0) check("if_request", 32'(o_if_request), 32'(exp_req_q.pop_front()));
      if (sens_q.size() > 0) begin
        s = sens_q.pop_front();
        repeat (s.delay) @(posedge i_Clock);
        #1;
        i_if_data = s.data;
        i_if_comandos = s.cmd;
        i_if_done = 1'b1;
        @(posedge i_Clock);
        #1;
        i_if_done = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int n;
    n = 0;
    while (!o_cmd_ready && n < 400) begin
      tick();
      n++;
    end
    check("ready_before_send", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int k;
    k = 0;
    while (resp_seen < n && k < 2000) begin
      tick();
      k++;
    end
    check("resp_count", 32'(resp_seen), 32'(n));
  endtask

  initial begin
    int rb, pb, k, n0;
    repeat (3) tick();
    check("rst_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_en", 32'(o_if_en), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_request", 32'(o_if_request), 32'h00);
    check("rst_cont_temp", 32'(o_cont_temp), 32'd0);
    check("rst_cont_hum", 32'(o_cont_hum), 32'd0);
    i_Rst = 1'b0;
    tick();

    // One-shot temperature read and issue latency.
    exp_req_q.push_back(8'h32);
    exp_resp_q.push_back({8'h1A, 6'b001000, 1'b0});
    sens_q.push_back('{8'h1A, 6'b001000, 3});
    send_cmd(8'h32);
    check("en_after_accept", 32'(o_if_en), 32'd0);
    tick();
    check("en_after_decide", 32'(o_if_en), 32'd0);
    tick();
    check("en_after_issue", 32'(o_if_en), 32'd1);
    check("request_at_issue", 32'(o_if_request), 32'h32);
    wait_resp(1);

    // Status command accepted during guard: issues exactly guard + idle + issue later.
    exp_req_q.push_back(8'h31);
    exp_resp_q.push_back({8'h55, 6'b000100, 1'b0});
    sens_q.push_back('{8'h55, 6'b000100, 2});
    send_cmd(8'h31);
    wait_resp(2);
    check("guard_gap", 32'(rise_cyc[1] - resp_cyc[0]), 32'(G + 2));

    // Continuous monitoring: two one-shots, then alternating 0x32 / 0x33 / 0x32.
    rb = rise_cyc.size();
    pb = resp_cyc.size();
    exp_req_q.push_back(8'h32); exp_resp_q.push_back({8'h21, 6'b001000, 1'b0}); sens_q.push_back('{8'h21, 6'b001000, 2});
    exp_req_q.push_back(8'h33); exp_resp_q.push_back({8'h22, 6'b000100, 1'b0}); sens_q.push_back('{8'h22, 6'b000100, 2});
    exp_req_q.push_back(8'h32); exp_resp_q.push_back({8'h23, 6'b001000, 1'b1}); sens_q.push_back('{8'h23, 6'b001000, 2});
    exp_req_q.push_back(8'h33); exp_resp_q.push_back({8'h24, 6'b000100, 1'b1}); sens_q.push_back('{8'h24, 6'b000100, 2});
    exp_req_q.push_back(8'h32); exp_resp_q.push_back({8'h25, 6'b001000, 1'b1}); sens_q.push_back('{8'h25, 6'b001000, 2});
    send_cmd(8'h34);
    check("cont_temp_set", 32'(o_cont_temp), 32'd1);
    send_cmd(8'h35);
    check("cont_hum_set", 32'(o_cont_hum), 32'd1);
    wait_resp(7);
    for (int i = 1; i < 5; i++)
      check("cont_gap", 32'(rise_cyc[rb + i] - resp_cyc[pb + i - 1]), 32'(G + 2));

    // Clear humidity, queue a one-shot behind it; temp continuous then times out.
    exp_req_q.push_back(8'h37); exp_resp_q.push_back({8'h00, 6'b100000, 1'b0}); sens_q.push_back('{8'h00, 6'b100000, 2});
    exp_req_q.push_back(8'h33); exp_resp_q.push_back({8'h31, 6'b000100, 1'b0}); sens_q.push_back('{8'h31, 6'b000100, 2});
    exp_req_q.push_back(8'h32); exp_resp_q.push_back({8'h86, 6'b000001, 1'b1});
    send_cmd(8'h37);
    check("ready_while_pending", 32'(o_cmd_ready), 32'd0);
    check("cont_hum_cleared", 32'(o_cont_hum), 32'd0);
    send_cmd(8'h33);
    wait_resp(10);
    check("timeout_span", 32'(resp_cyc[9] - rise_cyc[9]), 32'(T + R));
`ifdef SCHED_DROP_CONT_ON_ERROR_EN
    check("cont_temp_after_timeout", 32'(o_cont_temp), 32'd0);
`else
    check("cont_temp_after_timeout", 32'(o_cont_temp), 32'd1);
`endif

    // Unknown command: immediate error response, no interface activity.
    exp_resp_q.push_back({8'hFF, 6'b000001, 1'b0});
    send_cmd(8'h99);
    check("bad_valid_next", 32'(o_resp_valid), 32'd1);
    check("bad_data", 32'(o_resp_data), 32'hFF);
    check("bad_en", 32'(o_if_en), 32'd0);
    wait_resp(11);

    // Reset while waiting for the interface.
    exp_req_q.push_back(8'h32);
    send_cmd(8'h34);
    k = 0;
    while (!o_if_en && k < 200) begin
      tick();
      k++;
    end
    check("en_before_reset", 32'(o_if_en), 32'd1);
    tick();
    tick();
    i_Rst = 1'b1;
    tick();
    check("reset_en", 32'(o_if_en), 32'd0);
    check("reset_cont_temp", 32'(o_cont_temp), 32'd0);
    check("reset_cont_hum", 32'(o_cont_hum), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_ready", 32'(o_cmd_ready), 32'd1);
    i_Rst = 1'b0;
    n0 = rise_seen;
    repeat (40) tick();
    check("no_issue_after_reset", 32'(rise_seen), 32'(n0));
    check("resp_queue_drained", 32'(exp_resp_q.size()), 32'd0);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sensor_scheduler.md
Name: sensor_scheduler

Overview:
- Sequences the DHT11 sensor interface: owns its enable/request handshake and shares it between one-shot host commands from the UART decoder and the continuous temperature/humidity monitoring requesters.
- Enforces a guard interval between sensor transactions.
- Provides a timeout watchdog.
- Returns one response (comandos, data) per transaction to the UART response encoder.

Parameters:
- GUARD_CYCLES, 100_000_000, idle cycles after each transaction before the next one may issue (2 s at 50 MHz).
- TIMEOUT_CYCLES, 50_000_000, maximum cycles from o_if_en rise to i_if_done before aborting.
- RELEASE_CYCLES, 2, cycles o_if_en is held low after done/timeout before the response is emitted (must be >=2).

Ports:
- i_Clock  in  1  system clock, 50 MHz
- i_Rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  host command byte valid
- i_cmd  in  8  host command byte
- o_cmd_ready  out  1  pending-command buffer empty; command accepted when i_cmd_valid && o_cmd_ready
- o_if_en  out  1  enable to sensor interface
- o_if_request  out  8  request byte to sensor interface
- i_if_done  in  1  one-cycle done pulse from interface
- i_if_data  in  8  interface data byte
- i_if_comandos  in  6  interface response command bits
- o_resp_valid  out  1  one-cycle response strobe
- o_resp_data  out  8  response data
- o_resp_comandos  out  6  response command bits
- o_resp_cont  out  1  1 = response originates from a continuous-monitoring read
- o_busy  out  1  state != IDLE
- o_cont_temp  out  1  continuous temperature monitoring active
- o_cont_hum  out  1  continuous humidity monitoring active

Behaviour:
- Reset values: all outputs 0; o_cmd_ready = 1 (pending buffer empty); o_if_request = 0x00; state = IDLE; counters = 0; round-robin pointer = temperature.
- Reset mid-transaction drops o_if_en on the next edge and clears all flags.
- Command codes:
  - 0x31 status, 0x32 temperature, 0x33 humidity: forwarded unchanged.
  - 0x34: sets cont_temp at acceptance, then executes as 0x32.
  - 0x35: sets cont_hum at acceptance, then executes as 0x33.
  - 0x36 / 0x37: clear cont_temp / cont_hum at acceptance, then forwarded unchanged (interface acknowledges with 010000 / 100000).
  - Any other code: accepted; no interface transaction; the response 000001/0xFF is emitted the cycle after acceptance, even while busy.
- Pending buffer: one entry; o_cmd_ready = !pending.
- States:
  - IDLE: if pending, load o_if_request from the pending command, clear pending, o_resp_cont = 0 -> ISSUE. Else if cont_temp or cont_hum, select per the round-robin pointer (alternates temp/hum when both are set), request 0x32/0x33, o_resp_cont = 1 -> ISSUE. A pending one-shot always wins over continuous.
  - ISSUE: o_if_en <= 1, clear timeout counter -> WAIT_DONE.
  - WAIT_DONE: o_if_request held stable. On i_if_done, capture i_if_data and i_if_comandos -> RELEASE. If the counter reaches TIMEOUT_CYCLES-1 without done, capture comandos 000001 and data 0x86 -> RELEASE. Done and timeout in the same cycle: done wins.
  - RELEASE: o_if_en = 0 for RELEASE_CYCLES, then pulse o_resp_valid for one cycle with the captured values -> GUARD. The round-robin pointer advances only when the response is continuous.
  - GUARD: count GUARD_CYCLES, then -> IDLE. Commands may be accepted into the pending buffer during any state.
- Latency: command accepted at edge N while IDLE -> IDLE decision at N+1 -> o_if_en high after edge N+2.
- A continuous flag cleared while its read is in flight does not cancel that read; the response is still emitted with o_resp_cont = 1.
- i_if_done outside WAIT_DONE is ignored.
- Counters are sized $clog2(max(param)) + 1 and never wrap.

Optional Feature:
- SCHED_DROP_CONT_ON_ERROR_EN defined: any continuous-read response with comandos == 000001 (interface error or timeout) clears the corresponding cont flag in the same cycle o_resp_valid pulses.
- Not defined: continuous flags are cleared only by 0x36/0x37 or reset.

Test Plan:
- Bench parameters: GUARD_CYCLES=20, TIMEOUT_CYCLES=50, RELEASE_CYCLES=2.
- Cmd 0x32 while idle; interface done with data 0x1A, comandos 001000 -> o_if_en high 2 cycles after accept, o_if_request = 0x32; o_resp_valid with 0x1A/001000, o_resp_cont = 0; next issue no earlier than 20 cycles later.
- Cmd 0x34, then 0x35 -> o_cont_temp and o_cont_hum set; after each response the requests alternate 0x32, 0x33, 0x32, each with o_resp_cont = 1 and spaced by the guard interval.
- Cont_temp active and cmd 0x33 accepted during GUARD -> the next transaction issues 0x33 (one-shot priority); second cmd during busy sees o_cmd_ready = 0 until the first is dequeued.
- No i_if_done for 50 cycles -> o_if_en drops; response 000001/0x86 emitted after the 2 release cycles; with SCHED_DROP_CONT_ON_ERROR_EN on a continuous read, o_cont_temp also clears.
- Cmd 0x99 -> response 000001/0xFF the next cycle, o_if_en stays 0.
- i_Rst asserted mid-WAIT_DONE -> o_if_en, o_cont_* and o_busy = 0 after the next edge; o_cmd_ready = 1.
